// File: rtl/icache_mem_seq.sv
// icache_mem_seq: per-way SRAM command sequencer for the L1 icache.
// Turns one accepted request into per-way cs/we/be strobes for data and tag memories.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   req_valid_i/req_ready_o   request handshake (ready only in IDLE)
//   req_op_i                  0 ReadSet, 1 WriteLineAndTag, 2 InvalidSet, 3 InvalidAll
//   req_set_i, req_way_i      target set and way mask
//   beat_valid_i/beat_ready_o refill word handshake (WRITE only)
//   dmem_cs_o/we_o/be_o       per-way data-memory strobes
//   tmem_cs_o/we_o            per-way tag/valid-memory strobes
//   mem_addr_o, beat_idx_o    shared set address, word index within line
//   done_o, busy_o            final-command pulse, non-IDLE flag
//
// Build option: define ICACHE_MEM_SEQ_FLUSH_EN to compile in the
// whole-cache invalidate walk (op 3). Otherwise op 3 acts as InvalidSet.
module icache_mem_seq #(
    parameter int N_WAY      = 4,
    parameter int N_SETS     = 64,
    parameter int N_BEATS    = 4,
    parameter int WORD_BYTES = 8,
    localparam int IDX_W     = $clog2(N_SETS),
    localparam int BEAT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_op_i,
    input  logic [IDX_W-1:0]            req_set_i,
    input  logic [N_WAY-1:0]            req_way_i,
    input  logic                        beat_valid_i,
    output logic                        beat_ready_o,
    output logic [N_WAY-1:0]            dmem_cs_o,
    output logic [N_WAY-1:0]            dmem_we_o,
    output logic [N_WAY*WORD_BYTES-1:0] dmem_be_o,
    output logic [N_WAY-1:0]            tmem_cs_o,
    output logic [N_WAY-1:0]            tmem_we_o,
    output logic [IDX_W-1:0]            mem_addr_o,
    output logic [BEAT_W-1:0]           beat_idx_o,
    output logic                        done_o,
    output logic                        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_INV_SET,
        S_INV_ALL
    } state_t;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_BEATS - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_set;
    logic [N_WAY-1:0]   r_way;
    logic [BEAT_W-1:0]  r_beat;
    logic [N_WAY-1:0]   w_be_sel;

`ifdef ICACHE_MEM_SEQ_FLUSH_EN
    localparam logic [IDX_W-1:0] SET_LAST = IDX_W'(N_SETS - 1);
    logic [IDX_W-1:0]   r_cnt;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_set   <= '0;
            r_way   <= '0;
            r_beat  <= '0;
`ifdef ICACHE_MEM_SEQ_FLUSH_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_set <= req_set_i;
                        r_way <= req_way_i;
                        case (req_op_i)
                            2'd0:    r_state <= S_READ;
                            2'd1:    r_state <= S_WRITE;
                            2'd2:    r_state <= S_INV_SET;
`ifdef ICACHE_MEM_SEQ_FLUSH_EN
                            default: r_state <= S_INV_ALL;
`else
                            default: r_state <= S_INV_SET;
`endif
                        endcase
                    end
                end
                S_READ, S_INV_SET: r_state <= S_IDLE;
                S_WRITE: begin
                    // The counter only moves on a consumed beat, so stalls
                    // simply stretch the WRITE state.
                    if (beat_valid_i) begin
                        if (r_beat == BEAT_LAST) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_INV_ALL: begin
`ifdef ICACHE_MEM_SEQ_FLUSH_EN
                    if (r_cnt == SET_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);

    always_comb begin
        beat_ready_o = 1'b0;
        dmem_cs_o    = '0;
        dmem_we_o    = '0;
        w_be_sel     = '0;
        tmem_cs_o    = '0;
        tmem_we_o    = '0;
        mem_addr_o   = '0;
        beat_idx_o   = '0;
        done_o       = 1'b0;
        case (r_state)
            S_READ: begin
                dmem_cs_o  = '1;
                tmem_cs_o  = '1;
                w_be_sel   = '1;
                mem_addr_o = r_set;
                done_o     = 1'b1;
            end
            S_WRITE: begin
                beat_ready_o = 1'b1;
                mem_addr_o   = r_set;
                beat_idx_o   = r_beat;
                if (beat_valid_i) begin
                    dmem_cs_o = r_way;
                    dmem_we_o = r_way;
                    w_be_sel  = r_way;
                    // Tag/valid is written with the last word so a line
                    // never looks valid before all its data is in place.
                    if (r_beat == BEAT_LAST) begin
                        tmem_cs_o = r_way;
                        tmem_we_o = r_way;
                        done_o    = 1'b1;
                    end
                end
            end
            S_INV_SET: begin
                tmem_cs_o  = '1;
                tmem_we_o  = '1;
                mem_addr_o = r_set;
                done_o     = 1'b1;
            end
            S_INV_ALL: begin
`ifdef ICACHE_MEM_SEQ_FLUSH_EN
                tmem_cs_o  = '1;
                tmem_we_o  = '1;
                mem_addr_o = r_cnt;
                done_o     = (r_cnt == SET_LAST);
`endif
            end
            default: ;
        endcase
    end

    // Byte enables are a per-way broadcast of the selected-way vector.
    always_comb begin
        dmem_be_o = '0;
        for (int w = 0; w < N_WAY; w++) begin
            dmem_be_o[w*WORD_BYTES +: WORD_BYTES] = {WORD_BYTES{w_be_sel[w]}};
        end
    end

endmodule

// File: tb/tb_icache_mem_seq.sv
// tb_icache_mem_seq: randomized self-checking bench for icache_mem_seq.
// Compares every cycle of each transaction against a transaction-level model.
module tb_icache_mem_seq;

    localparam int NW = 4;
    localparam int NS = 64;
    localparam int NB = 4;
    localparam int WB = 8;

`ifdef ICACHE_MEM_SEQ_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    typedef struct packed {
        logic [NW-1:0]    dcs;
        logic [NW-1:0]    dwe;
        logic [NW*WB-1:0] dbe;
        logic [NW-1:0]    tcs;
        logic [NW-1:0]    twe;
        logic [5:0]       addr;
        logic [1:0]       bidx;
        logic             done;
        logic             busy;
        logic             rdy;
        logic             brdy;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [5:0]       req_set = '0;
    logic [NW-1:0]    req_way = '0;
    logic             beat_valid = 1'b0;
    logic             beat_ready;
    logic [NW-1:0]    dmem_cs;
    logic [NW-1:0]    dmem_we;
    logic [NW*WB-1:0] dmem_be;
    logic [NW-1:0]    tmem_cs;
    logic [NW-1:0]    tmem_we;
    logic [5:0]       mem_addr;
    logic [1:0]       beat_idx;
    logic             done;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    icache_mem_seq #(
        .N_WAY(NW), .N_SETS(NS), .N_BEATS(NB), .WORD_BYTES(WB)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i(req_op),
        .req_set_i(req_set),
        .req_way_i(req_way),
        .beat_valid_i(beat_valid),
        .beat_ready_o(beat_ready),
        .dmem_cs_o(dmem_cs),
        .dmem_we_o(dmem_we),
        .dmem_be_o(dmem_be),
        .tmem_cs_o(tmem_cs),
        .tmem_we_o(tmem_we),
        .mem_addr_o(mem_addr),
        .beat_idx_o(beat_idx),
        .done_o(done),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t observe();
        obs_t o;
        o.dcs  = dmem_cs;
        o.dwe  = dmem_we;
        o.dbe  = dmem_be;
        o.tcs  = tmem_cs;
        o.twe  = tmem_we;
        o.addr = mem_addr;
        o.bidx = beat_idx;
        o.done = done;
        o.busy = busy;
        o.rdy  = req_ready;
        o.brdy = beat_ready;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    function automatic logic [NW*WB-1:0] be_of(input logic [NW-1:0] m);
        logic [NW*WB-1:0] b;
        b = '0;
        for (int w = 0; w < NW; w++)
            if (m[w]) b[w*WB +: WB] = {WB{1'b1}};
        return b;
    endfunction

    function automatic bit bv_at(input bit q[$], input int i);
        return (i < q.size()) ? q[i] : 1'b1;
    endfunction

    // Transaction-level reference: accept cycle, command cycles, idle cycle.
    function automatic void model(input logic [1:0] op, input logic [5:0] set,
                                  input logic [NW-1:0] way, input bit bv[$],
                                  output obs_t e[$]);
        obs_t o;
        int   k;
        int   j;
        logic [1:0] eop;
        e = {};
        e.push_back(idle_obs());
        eop = (op == 2'd3 && !FLUSH) ? 2'd2 : op;
        case (eop)
            2'd0: begin
                o = '0; o.busy = 1'b1; o.addr = set; o.done = 1'b1;
                o.dcs = '1; o.tcs = '1; o.dbe = '1;
                e.push_back(o);
            end
            2'd2: begin
                o = '0; o.busy = 1'b1; o.addr = set; o.done = 1'b1;
                o.tcs = '1; o.twe = '1;
                e.push_back(o);
            end
            2'd3: begin
                for (int a = 0; a < NS; a++) begin
                    o = '0; o.busy = 1'b1; o.tcs = '1; o.twe = '1;
                    o.addr = 6'(a);
                    o.done = (a == NS - 1);
                    e.push_back(o);
                end
            end
            default: begin
                k = 0;
                j = 0;
                while (k < NB) begin
                    o = '0; o.busy = 1'b1; o.brdy = 1'b1;
                    o.addr = set; o.bidx = 2'(k);
                    if (bv_at(bv, j)) begin
                        o.dcs = way; o.dwe = way; o.dbe = be_of(way);
                        if (k == NB - 1) begin
                            o.tcs = way; o.twe = way; o.done = 1'b1;
                        end
                        k++;
                    end
                    j++;
                    e.push_back(o);
                end
            end
        endcase
        e.push_back(idle_obs());
    endfunction

    // Drives one request for n cycles and records the outputs each cycle.
    task automatic drive_txn(input logic [1:0] op, input logic [5:0] set,
                             input logic [NW-1:0] way, input bit bv[$],
                             input int n, input bit junk, output obs_t got[$]);
        got = {};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b1; req_op = op; req_set = set; req_way = way;
                beat_valid = 1'b0;
            end else if (i == n - 1) begin
                req_valid = 1'b0; beat_valid = 1'b0;
            end else begin
                req_valid = junk;
                req_op = 2'($urandom);
                req_set = 6'($urandom);
                req_way = 4'($urandom);
                beat_valid = bv_at(bv, i - 1);
            end
            #1;
            got.push_back(observe());
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (observe() !== idle_obs()) begin
            n_fail++;
            $display("FAIL reset_state got %h exp %h", observe(), idle_obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_set();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        logic [5:0] s;
        for (int t = 0; t < 6; t++) begin
            s = (t == 0) ? 6'd5 : 6'($urandom);
            model(2'd0, s, 4'($urandom), bv, e);
            drive_txn(2'd0, s, 4'($urandom), bv, e.size(), t[0], g);
            for (int i = 0; i < e.size(); i++) begin
                n_checks++;
                if (g[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL read_set t%0d cyc%0d got %h exp %h", t, i, g[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_write_line();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        logic [5:0] s;
        logic [NW-1:0] w;
        for (int t = 0; t < 8; t++) begin
            bv = {};
            if (t == 0) begin
                s = 6'd9; w = 4'b0100;
                bv = '{1, 0, 1, 1, 1};
            end else begin
                s = 6'($urandom);
                w = (t == 1) ? 4'b1011 : 4'($urandom);
                for (int b = 0; b < 10; b++) bv.push_back(bit'($urandom));
            end
            model(2'd1, s, w, bv, e);
            drive_txn(2'd1, s, w, bv, e.size(), 1'b1, g);
            for (int i = 0; i < e.size(); i++) begin
                n_checks++;
                if (g[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL write_line t%0d cyc%0d got %h exp %h", t, i, g[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_zero_mask();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        bv = '{1, 1, 0, 1, 1};
        model(2'd1, 6'd17, 4'b0000, bv, e);
        drive_txn(2'd1, 6'd17, 4'b0000, bv, e.size(), 1'b0, g);
        for (int i = 0; i < e.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL zero_mask cyc%0d got %h exp %h", i, g[i], e[i]);
            end
        end
    endtask

    task automatic test_inv_set();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        logic [5:0] s;
        for (int t = 0; t < 4; t++) begin
            s = (t == 0) ? 6'd63 : 6'($urandom);
            model(2'd2, s, 4'($urandom), bv, e);
            drive_txn(2'd2, s, 4'($urandom), bv, e.size(), 1'b1, g);
            for (int i = 0; i < e.size(); i++) begin
                n_checks++;
                if (g[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL inv_set t%0d cyc%0d got %h exp %h", t, i, g[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_inv_all();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        logic [5:0] s;
        for (int t = 0; t < 2; t++) begin
            s = 6'($urandom);
            model(2'd3, s, 4'($urandom), bv, e);
            drive_txn(2'd3, s, 4'($urandom), bv, e.size(), t[0], g);
            for (int i = 0; i < e.size(); i++) begin
                n_checks++;
                if (g[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL inv_all t%0d cyc%0d got %h exp %h", t, i, g[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        logic [1:0] op;
        logic [5:0] s;
        logic [NW-1:0] w;
        for (int t = 0; t < 16; t++) begin
            op = 2'($urandom);
            s = 6'($urandom);
            w = 4'($urandom);
            bv = {};
            for (int b = 0; b < 8; b++) bv.push_back(bit'($urandom));
            model(op, s, w, bv, e);
            drive_txn(op, s, w, bv, e.size(), 1'b1, g);
            for (int i = 0; i < e.size(); i++) begin
                n_checks++;
                if (g[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL back_to_back t%0d op%0d cyc%0d got %h exp %h",
                             t, op, i, g[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        obs_t e[$];
        obs_t g[$];
        bit   bv[$];
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_set = 6'd33; req_way = 4'b1010;
        beat_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; beat_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (beat_idx !== 2'd2 || busy !== 1'b1 || dmem_we !== 4'b1010) begin
            n_fail++;
            $display("FAIL mid_write_beat got idx %0d busy %0b we %b exp idx 2 busy 1 we 1010",
                     beat_idx, busy, dmem_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (observe() !== idle_obs()) begin
            n_fail++;
            $display("FAIL reset_async got %h exp %h", observe(), idle_obs());
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (observe() !== idle_obs()) begin
            n_fail++;
            $display("FAIL reset_hold got %h exp %h", observe(), idle_obs());
        end
        rst_n = 1'b1;
        beat_valid = 1'b0;
        bv = '{1, 1, 1, 1};
        model(2'd1, 6'd40, 4'b0001, bv, e);
        drive_txn(2'd1, 6'd40, 4'b0001, bv, e.size(), 1'b0, g);
        for (int i = 0; i < e.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL restart_write cyc%0d got %h exp %h", i, g[i], e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_set();
        test_write_line();
        test_zero_mask();
        test_inv_set();
        test_inv_all();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_mem_seq.md
# icache_mem_seq

Parametrised multi-cycle command sequencer for the L1 instruction-cache data and tag/valid memories. It sits between the icache control unit and the SRAM macros and turns one accepted request into per-way chip-select, write-enable and byte-enable strobes. It generalises the single-cycle memory control to any associativity. It adds beat-wise line refill with a data handshake and a whole-cache invalidate walk.

## Interface
- N_WAY, 4: associativity; number of data and tag memories.
- N_SETS, 64: sets per way, power of two, at least 2.
- N_BEATS, 4: data words per line, power of two, at least 1.
- WORD_BYTES, 8: bytes per data-memory word.
- Derived widths: IDX_W = $clog2(N_SETS); BEAT_W = max(1, $clog2(N_BEATS)).
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request can be accepted.
- req_op_i  in  2  0 ReadSet, 1 WriteLineAndTag, 2 InvalidSet, 3 InvalidAll.
- req_set_i  in  IDX_W  target set index.
- req_way_i  in  N_WAY  replacement vector (way mask for WriteLineAndTag).
- beat_valid_i  in  1  refill data word present on the external data bus.
- beat_ready_o  out  1  sequencer consumes the refill word this cycle.
- dmem_cs_o, dmem_we_o  out  N_WAY  per-way data-memory chip select and write enable.
- dmem_be_o  out  N_WAY*WORD_BYTES  per-way byte enables.
- tmem_cs_o, tmem_we_o  out  N_WAY  per-way tag/valid-memory chip select and write enable.
- mem_addr_o  out  IDX_W  set address shared by all memories.
- beat_idx_o  out  BEAT_W  word index within the line.
- done_o  out  1  one-cycle pulse in the final command cycle.
- busy_o  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, READ, WRITE, INV_SET, INV_ALL.
- Registered: state, latched op, set index, way mask, beat counter, set counter.
- All memory outputs are combinational from the registered state plus beat_valid_i, and are all zero in IDLE.
- req_ready_o = (state == IDLE). A request is accepted when req_valid_i and req_ready_o are both high. The accepted request is latched and the FSM moves to the op state.
- READ: dmem_cs_o and tmem_cs_o are all ones; dmem_be_o is all ones; we is 0; done_o is 1. Next state is IDLE.
- WRITE:
  - beat_ready_o = 1.
  - On a beat handshake: dmem_cs_o = dmem_we_o = way mask; the selected ways' be are all ones; beat_idx_o = beat counter.
  - The counter then increments.
  - On the beat where the counter equals N_BEATS-1, tmem_cs_o = tmem_we_o = way mask, done_o = 1, the counter wraps to 0 and the FSM returns to IDLE.
  - With no beat_valid_i, no strobes are asserted.
- INV_SET: tmem_cs_o = tmem_we_o = all ones; done_o = 1; next state is IDLE.
- INV_ALL:
  - mem_addr_o = set counter, starting at 0; tmem_cs_o = tmem_we_o = all ones every cycle.
  - The counter increments each cycle.
  - At N_SETS-1: done_o = 1, the counter wraps to 0 and the FSM returns to IDLE.
- mem_addr_o = latched set index in every non-IDLE state except INV_ALL, and 0 in IDLE.
- Boundaries:
  - All-zero way mask: beats are still consumed and done_o still pulses, with no strobes.
  - Multi-hot mask: every flagged way is written.
  - N_BEATS = 1: data and tag are written in the same cycle.
  - Requests while busy are not accepted and are ignored.
  - Reset mid-operation forces IDLE, clears both counters and drops all strobes immediately.

## Timing
- Reset values: req_ready_o = 1; all other outputs 0.
- Acceptance at cycle t puts the first command at t+1.
- Latency from acceptance to done_o:
  - ReadSet and InvalidSet: 1 cycle.
  - WriteLineAndTag: at least N_BEATS cycles, plus any stall cycles.
  - InvalidAll: N_SETS cycles.
- req_ready_o returns high in the cycle after done_o, so the minimum request spacing is 2 cycles.
- Read data is valid one cycle after the READ strobe (SRAM latency); capturing it is the requester's job.

## Configuration
- ICACHE_MEM_SEQ_FLUSH_EN defined: INV_ALL state and the set counter are compiled in; op 3 walks every set as described above.
- Not defined: op 3 behaves exactly like InvalidSet on req_set_i (single cycle). No set counter is instantiated.

## Test plan
- Reset with rst_n_i low mid-WRITE (beat 2 of 4) -> next cycle all strobes are 0, req_ready_o = 1; a new WriteLineAndTag restarts at beat_idx_o = 0.
- ReadSet, set 5, N_WAY = 4 -> one cycle with dmem_cs_o = tmem_cs_o = 4'b1111, we = 0, mem_addr_o = 5, done_o = 1; req_ready_o = 1 the following cycle.
- WriteLineAndTag, way 4'b0100, set 9, beat_valid_i toggling 1,0,1,1,1 -> dmem_we_o = 4'b0100 on exactly 4 cycles with beat_idx_o 0,1,2,3; tmem_we_o and done_o only on the beat-3 cycle.
- InvalidSet, set 63 -> tmem_cs_o = tmem_we_o = 4'b1111 for one cycle, dmem_cs_o = 0, mem_addr_o = 63.
- InvalidAll with flush enabled -> 64 consecutive cycles with mem_addr_o = 0..63 and tag writes on all ways, done_o only at address 63. With the macro undefined -> single cycle at req_set_i.
- WriteLineAndTag with way mask 0 -> 4 beats consumed, no cs, done_o on the 4th beat.
